// File: rtl/alu_seq_core_pkg.sv
// Shared types for the sequential ALU core: opcodes, flag bundle and FSM states.
package alu_seq_core_pkg;

   localparam int unsigned ALU_DATA_WIDTH = 8;

   typedef enum logic [3:0] {
      OP_ADD    = 4'h0,
      OP_SUB    = 4'h1,
      OP_MUL    = 4'h2,
      OP_DIV    = 4'h3,
      OP_AND    = 4'h4,
      OP_OR     = 4'h5,
      OP_NAND   = 4'h6,
      OP_NOR    = 4'h7,
      OP_XOR    = 4'h8,
      OP_XNOR   = 4'h9,
      OP_CMP_EQ = 4'hA,
      OP_CMP_GT = 4'hB,
      OP_SHR    = 4'hC,
      OP_SHL    = 4'hD,
      OP_ROR    = 4'hE,
      OP_ROL    = 4'hF
   } alu_op_e;

   typedef struct packed {
      logic cf;
      logic of;
      logic zf;
      logic ef;
   } alu_flags_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_DIV  = 2'd1,
      ST_HOLD = 2'd2
   } alu_seq_state_e;

endpackage

// File: rtl/alu_seq_core_divider.sv
// Iterative restoring divider, one quotient bit per cycle; signed operands are
// divided as magnitudes and the signs applied to the outputs.
module alu_seq_divider
   import alu_seq_core_pkg::*;
#(
   parameter int unsigned W = ALU_DATA_WIDTH
) (
   input  logic         CLK,
   input  logic         RST,
   input  logic         start,
   input  logic         sgn,
   input  logic [W-1:0] dividend,
   input  logic [W-1:0] divisor,
   output logic         dbz,
   output logic         done,
   output logic [W-1:0] quotient,
   output logic [W-1:0] remainder,
   output logic         ovf
);
   localparam int unsigned CW = $clog2(W);

   logic          running;
   logic [CW-1:0] cnt;
   logic [W-1:0]  rem_r, quo_r, dvs_r;
   logic          neg_q, neg_r, ovf_r;
   logic [W:0]    shifted, trial;
   logic [W-1:0]  rem_n, quo_n, q_raw, r_raw;
   logic [W-1:0]  a_abs, b_abs;

   assign dbz = (divisor == '0);
   assign ovf = ovf_r;

   always_comb begin
      a_abs   = (sgn && dividend[W-1]) ? -dividend : dividend;
      b_abs   = (sgn && divisor[W-1]) ? -divisor : divisor;
      shifted = {rem_r, quo_r[W-1]};
      trial   = shifted - {1'b0, dvs_r};
      rem_n   = trial[W] ? shifted[W-1:0] : trial[W-1:0];
      quo_n   = {quo_r[W-2:0], ~trial[W]};
      done    = running && (cnt == '0);
      // On the final step the answer is still combinational; afterwards it is held in the registers.
      q_raw     = done ? quo_n : quo_r;
      r_raw     = done ? rem_n : rem_r;
      quotient  = neg_q ? -q_raw : q_raw;
      remainder = neg_r ? -r_raw : r_raw;
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         running <= 1'b0;
         cnt     <= '0;
         rem_r   <= '0;
         quo_r   <= '0;
         dvs_r   <= '0;
         neg_q   <= 1'b0;
         neg_r   <= 1'b0;
         ovf_r   <= 1'b0;
      end else if (start) begin
         running <= 1'b1;
         cnt     <= CW'(W - 1);
         rem_r   <= '0;
         quo_r   <= a_abs;
         dvs_r   <= b_abs;
         neg_q   <= sgn && (dividend[W-1] ^ divisor[W-1]);
         neg_r   <= sgn && dividend[W-1];
         ovf_r   <= sgn && (dividend == {1'b1, {(W-1){1'b0}}}) && (divisor == '1);
      end else if (running) begin
         rem_r <= rem_n;
         quo_r <= quo_n;
         cnt   <= cnt - 1'b1;
         if (cnt == '0)
            running <= 1'b0;
      end
   end

endmodule

// File: rtl/alu_seq_core.sv
// Registered, valid/ready ALU with iterative divide.
// Optional macro ALU_SEQ_SIGNED_EN adds the op_signed input for signed MUL/DIV/CMP_GT/SHR.
module alu_seq_core
   import alu_seq_core_pkg::*;
#(
   parameter int unsigned DATA_WIDTH  = ALU_DATA_WIDTH,
   parameter int unsigned OP_WIDTH    = 4,
   parameter int unsigned SHAMT_WIDTH = $clog2(DATA_WIDTH)
) (
   input  logic                    CLK,
   input  logic                    RST,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [OP_WIDTH-1:0]     op,
   input  logic [DATA_WIDTH-1:0]   a,
   input  logic [DATA_WIDTH-1:0]   b,
`ifdef ALU_SEQ_SIGNED_EN
   input  logic                    op_signed,
`endif
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [2*DATA_WIDTH-1:0] result,
   output logic                    cf,
   output logic                    of,
   output logic                    zf,
   output logic                    ef,
   output logic                    busy
);
   localparam int unsigned W = DATA_WIDTH;

   alu_seq_state_e   state, state_nxt;
   logic             out_valid_r, div_ef_r;
   logic [2*W-1:0]   result_r;
   alu_flags_t       flags_r;
   logic             sgn, accept, div_op;
   logic             load_alu, load_div, div_start;
   logic             div_dbz, div_done, div_ovf;
   logic [W-1:0]     div_quo, div_rem;

`ifdef ALU_SEQ_SIGNED_EN
   assign sgn = op_signed;
`else
   assign sgn = 1'b0;
`endif

   logic [SHAMT_WIDTH-1:0] shamt;
   logic [W:0]             sum, diff, shl_ext, shr_ext;
   logic [W-1:0]           rot_r, rot_l;
   logic [2*W-1:0]         prod, alu_res;
   logic                   a_eq_b, a_gt_b, fa, fb, known, is_cmp;
   alu_flags_t             alu_flags, div_flags;

   always_comb begin
      shamt   = b[SHAMT_WIDTH-1:0];
      fa      = sgn & a[W-1];
      fb      = sgn & b[W-1];
      sum     = {1'b0, a} + {1'b0, b};
      diff    = {1'b0, a} - {1'b0, b};
      shl_ext = {1'b0, a} << shamt;
      // Extra low bit catches the last bit shifted out; the fill bits give arithmetic shift.
      shr_ext = (W+1)'({{W{fa}}, a, 1'b0} >> shamt);
      rot_r   = W'({a, a} >> shamt);
      rot_l   = W'(({a, a} << shamt) >> W);
      prod    = {{W{fa}}, a} * {{W{fb}}, b};
      a_eq_b  = (a == b);
      a_gt_b  = sgn ? ($signed(a) > $signed(b)) : (a > b);
      alu_res   = '0;
      alu_flags = '0;
      known     = 1'b1;
      is_cmp    = 1'b0;
      case (op)
         OP_ADD: begin
            alu_res[W-1:0] = sum[W-1:0];
            alu_flags.cf   = sum[W];
            alu_flags.of   = (a[W-1] == b[W-1]) && (sum[W-1] != a[W-1]);
         end
         OP_SUB: begin
            alu_res[W-1:0] = diff[W-1:0];
            alu_flags.cf   = diff[W];
            alu_flags.of   = (a[W-1] != b[W-1]) && (diff[W-1] != a[W-1]);
         end
         OP_MUL: begin
            alu_res      = prod;
            alu_flags.of = sgn ? (prod[2*W-1:W] != {W{prod[W-1]}}) : (prod[2*W-1:W] != '0);
         end
         OP_DIV: begin
            alu_res      = '1;
            alu_flags.cf = 1'b1;
         end
         OP_AND:  alu_res[W-1:0] = a & b;
         OP_OR:   alu_res[W-1:0] = a | b;
         OP_NAND: alu_res[W-1:0] = ~(a & b);
         OP_NOR:  alu_res[W-1:0] = ~(a | b);
         OP_XOR:  alu_res[W-1:0] = a ^ b;
         OP_XNOR: alu_res[W-1:0] = ~(a ^ b);
         OP_CMP_EQ: begin
            alu_res[0] = a_eq_b;
            is_cmp     = 1'b1;
         end
         OP_CMP_GT: begin
            alu_res[0] = a_gt_b;
            is_cmp     = 1'b1;
         end
         OP_SHR: begin
            alu_res[W-1:0] = shr_ext[W:1];
            alu_flags.cf   = shr_ext[0];
         end
         OP_SHL: begin
            alu_res[W-1:0] = shl_ext[W-1:0];
            alu_flags.cf   = shl_ext[W];
            alu_flags.of   = shl_ext[W-1] != a[W-1];
         end
         OP_ROR: begin
            alu_res[W-1:0] = rot_r;
            alu_flags.cf   = (shamt != '0) && rot_r[W-1];
         end
         OP_ROL: begin
            alu_res[W-1:0] = rot_l;
            alu_flags.cf   = (shamt != '0) && rot_l[0];
         end
         default: known = 1'b0;
      endcase
      if (known) begin
         alu_flags.zf = !is_cmp && (alu_res == '0);
         alu_flags.ef = a_eq_b;
      end
   end

   alu_seq_divider #(.W(W)) u_div (
      .CLK       (CLK),
      .RST       (RST),
      .start     (div_start),
      .sgn       (sgn),
      .dividend  (a),
      .divisor   (b),
      .dbz       (div_dbz),
      .done      (div_done),
      .quotient  (div_quo),
      .remainder (div_rem),
      .ovf       (div_ovf)
   );

   always_comb begin
      div_flags    = '0;
      div_flags.of = div_ovf;
      div_flags.zf = (div_quo == '0);
      div_flags.ef = div_ef_r;
   end

   assign in_ready = (state == ST_IDLE) && (!out_valid_r || out_ready);
   assign accept   = in_valid && in_ready;
   assign div_op   = (op == OP_DIV);

   always_comb begin
      state_nxt = state;
      load_alu  = 1'b0;
      load_div  = 1'b0;
      div_start = 1'b0;
      case (state)
         ST_IDLE: begin
            if (accept) begin
               if (div_op && !div_dbz) begin
                  div_start = 1'b1;
                  state_nxt = ST_DIV;
               end else begin
                  load_alu = 1'b1;
               end
            end
         end
         ST_DIV: begin
            if (div_done) begin
               if (!out_valid_r || out_ready) begin
                  load_div  = 1'b1;
                  state_nxt = ST_IDLE;
               end else begin
                  state_nxt = ST_HOLD;
               end
            end
         end
         ST_HOLD: begin
            if (out_ready) begin
               load_div  = 1'b1;
               state_nxt = ST_IDLE;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST)
         state <= ST_IDLE;
      else
         state <= state_nxt;
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         out_valid_r <= 1'b0;
         result_r    <= '0;
         flags_r     <= '0;
         div_ef_r    <= 1'b0;
      end else begin
         if (div_start)
            div_ef_r <= a_eq_b;
         if (load_alu) begin
            result_r <= alu_res;
            flags_r  <= alu_flags;
         end else if (load_div) begin
            result_r <= {div_rem, div_quo};
            flags_r  <= div_flags;
         end
         if (load_alu || load_div)
            out_valid_r <= 1'b1;
         else if (out_ready)
            out_valid_r <= 1'b0;
      end
   end

   assign out_valid = out_valid_r;
   assign result    = result_r;
   assign cf        = flags_r.cf;
   assign of        = flags_r.of;
   assign zf        = flags_r.zf;
   assign ef        = flags_r.ef;
   assign busy      = (state == ST_DIV);

endmodule

// File: tb/tb_alu_seq_core.sv
// Scoreboard bench for alu_seq_core: directed cases then randomized traffic against an arithmetic model.
`timescale 1ns/1ps
module tb_alu_seq_core;

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [3:0]  op = '0;
   logic [7:0]  a = '0, b = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [15:0] result;
   logic        cf, of, zf, ef, busy;

   int tests = 0;
   int fails = 0;

   typedef struct {
      logic [15:0] res;
      logic        cf, of, zf, ef;
   } exp_t;

   exp_t sb[$];
   exp_t em;
   bit   rdy_rand  = 1'b0;
   bit   rdy_force = 1'b1;

   always #5 CLK = ~CLK;

   alu_seq_core #(.DATA_WIDTH(8), .OP_WIDTH(4), .SHAMT_WIDTH(3)) dut (
      .CLK       (CLK),
      .RST       (RST),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op        (op),
      .a         (a),
      .b         (b),
`ifdef ALU_SEQ_SIGNED_EN
      .op_signed (1'b0),
`endif
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .cf        (cf),
      .of        (of),
      .zf        (zf),
      .ef        (ef),
      .busy      (busy)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got %0h want %0h at %0t", name, act, req, $time);
      end
   endtask

   // Unsigned 8-bit reference written from the opcode definitions with integer arithmetic.
   function automatic exp_t model(input int o, input int x, input int y);
      exp_t e;
      int   n, r, sx, sy;
      n  = y % 8;
      sx = (x >= 128) ? x - 256 : x;
      sy = (y >= 128) ? y - 256 : y;
      r  = 0;
      e.cf = 1'b0;
      e.of = 1'b0;
      case (o)
         0: begin r = x + y; e.cf = (r > 255); e.of = (sx + sy > 127) || (sx + sy < -128); r = r % 256; end
         1: begin r = (x - y + 256) % 256; e.cf = (x < y); e.of = (sx - sy > 127) || (sx - sy < -128); end
         2: begin r = x * y; e.of = (r > 255); end
         3: if (y == 0) begin r = 65535; e.cf = 1'b1; end
            else r = (x % y) * 256 + x / y;
         4: r = x & y;
         5: r = x | y;
         6: r = ~(x & y) & 255;
         7: r = ~(x | y) & 255;
         8: r = x ^ y;
         9: r = ~(x ^ y) & 255;
         10: r = (x == y) ? 1 : 0;
         11: r = (x > y) ? 1 : 0;
         12: begin r = x >> n; e.cf = (n != 0) && (((x >> (n - 1)) & 1) != 0); end
         13: begin
            r = (x << n) & 255;
            e.cf = (n != 0) && (((x >> (8 - n)) & 1) != 0);
            e.of = (n != 0) && ((r >> 7) != (x >> 7));
         end
         14: begin r = ((x >> n) | (x << (8 - n))) & 255; e.cf = (n != 0) && (((x >> (n - 1)) & 1) != 0); end
         default: begin r = ((x << n) | (x >> (8 - n))) & 255; e.cf = (n != 0) && (((x >> (8 - n)) & 1) != 0); end
      endcase
      e.res = r[15:0];
      if (o == 3)                e.zf = (y != 0) && (x / y == 0);
      else if (o == 10 || o == 11) e.zf = 1'b0;
      else                       e.zf = (r == 0);
      e.ef = (x == y);
      return e;
   endfunction

   always @(posedge CLK) begin
      #2;
      out_ready = rdy_rand ? ($urandom_range(0, 3) != 0) : rdy_force;
   end

   // Monitor: pops the scoreboard on every output handshake and watches output stability under backpressure.
   logic [15:0] held_res;
   logic [3:0]  held_flags;
   bit          holding = 1'b0;

   always @(negedge CLK) begin
      if (!RST) begin
         holding = 1'b0;
      end else begin
         if (holding) begin
            check("hold_valid", out_valid, 1);
            check("hold_result", result, held_res);
            check("hold_flags", {cf, of, zf, ef}, held_flags);
         end
         if (out_valid && !out_ready)
            check("bp_in_ready", in_ready, 0);
         holding    = out_valid && !out_ready;
         held_res   = result;
         held_flags = {cf, of, zf, ef};
         if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL unexpected_output: got %0h want none", result);
            end else begin
               em = sb.pop_front();
               check("result", result, em.res);
               check("flags_cf_of_zf_ef", {cf, of, zf, ef}, {em.cf, em.of, em.zf, em.ef});
            end
         end
      end
   end

   task automatic issue(input int o, input int x, input int y);
      int guard;
      guard    = 0;
      op       = 4'(o);
      a        = 8'(x);
      b        = 8'(y);
      in_valid = 1'b1;
      @(negedge CLK);
      while (!in_ready && guard < 200) begin
         @(negedge CLK);
         guard++;
      end
      if (!in_ready) begin
         tests++;
         fails++;
         $display("FAIL issue_timeout: got in_ready 0 want 1 (op %0d)", o);
         in_valid = 1'b0;
         return;
      end
      sb.push_back(model(o, x, y));
      @(posedge CLK);
      #1 in_valid = 1'b0;
   endtask

   task automatic div_latency(input int x, input int y, input int want);
      int lat, low, bsy;
      lat = 0; low = 0; bsy = 0;
      issue(3, x, y);
      do begin
         @(negedge CLK);
         lat++;
         if (!in_ready) low++;
         if (busy) bsy++;
      end while (!out_valid && lat < 40);
      check("div_latency", lat, want);
      check("div_in_ready_low", low, want - 1);
      check("div_busy_cycles", bsy, want - 1);
      @(posedge CLK); #1;
   endtask

   initial begin
      #1 RST = 1'b0;
      repeat (3) @(posedge CLK);
      #1;
      check("rst_out_valid", out_valid, 0);
      check("rst_result", result, 0);
      check("rst_flags", {cf, of, zf, ef}, 0);
      check("rst_busy", busy, 0);
      RST = 1'b1;
      @(posedge CLK); #3;
      check("idle_in_ready", in_ready, 1);

      issue(0, 'hFF, 'h01);
      issue(1, 'h80, 'h01);
      issue(2, 'h10, 'h10);
      div_latency('h64, 'h07, 9);
      div_latency('h05, 'h00, 1);
      issue(13, 'h81, 3);
      issue(14, 'h01, 1);
      issue(10, 'h5A, 'h5A);
      issue(11, 'h30, 'h20);

      repeat (3) @(posedge CLK);
      #1 rdy_force = 1'b0;
      @(posedge CLK); #1;
      issue(0, 3, 4);
      for (int k = 0; k < 5; k++) begin
         @(negedge CLK);
         check("bp_result", result, 16'h0007);
         check("bp_hold_in_ready", in_ready, 0);
      end
      @(posedge CLK); #1 rdy_force = 1'b1;
      issue(4, 'hF0, 'h3C);

      repeat (3) @(posedge CLK);
      #1;
      issue(3, 200, 3);
      repeat (3) @(negedge CLK);
      RST = 1'b0;
      #1;
      check("rst_div_out_valid", out_valid, 0);
      check("rst_div_busy", busy, 0);
      check("rst_div_in_ready", in_ready, 1);
      sb.delete();
      @(negedge CLK) RST = 1'b1;
      @(posedge CLK); #1;
      issue(1, 'h10, 'h20);

      rdy_rand = 1'b1;
      for (int i = 0; i < 300; i++) begin
         int o, x, y;
         o = $urandom_range(0, 15);
         x = $urandom_range(0, 255);
         y = ($urandom_range(0, 7) == 0) ? x : $urandom_range(0, 255);
         if (o == 3 && $urandom_range(0, 5) == 0) y = 0;
         issue(o, x, y);
         if ($urandom_range(0, 3) == 0) begin
            @(posedge CLK); #1;
         end
      end
      rdy_rand  = 1'b0;
      rdy_force = 1'b1;
      for (int g = 0; g < 200 && sb.size() != 0; g++)
         @(posedge CLK);
      check("scoreboard_drained", sb.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got no completion want finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/alu_seq_core.md
Name: alu_seq_core

Overview:
- Registered, handshaked successor to the combinational ALU function set.
- Accepts one operation per transaction on a valid/ready input port and returns a 2*DATA_WIDTH result plus CF/OF/ZF/EF flags on a valid/ready output port.
- Division is iterative: restoring, one quotient bit per cycle.
- Shifts take a variable amount from operand B.
- Sits between the UART RX frame decoder and the TX response builder in the UART command system.

Parameters:
- DATA_WIDTH, 8: operand width; the result is 2*DATA_WIDTH.
- OP_WIDTH, 4: opcode width.
- SHAMT_WIDTH, $clog2(DATA_WIDTH): number of low bits of B used as the shift amount.

Ports:
- CLK  in  1  system clock.
- RST  in  1  asynchronous active-low reset.
- in_valid  in  1  operation request.
- in_ready  out  1  core can accept an operation.
- op  in  OP_WIDTH  opcode (alu_op_e).
- a  in  DATA_WIDTH  operand A.
- b  in  DATA_WIDTH  operand B / shift amount.
- out_valid  out  1  result registered and valid.
- out_ready  in  1  consumer accepts the result.
- result  out  2*DATA_WIDTH  result; DIV places the remainder in the upper half and the quotient in the lower half.
- cf  out  1  carry / borrow / shifted-out bit / divide-by-zero.
- of  out  1  overflow.
- zf  out  1  zero.
- ef  out  1  A==B.
- busy  out  1  divide in progress.

Behaviour:
- Reset (RST=0, asynchronous): state=IDLE; out_valid, result, cf, of, zf, ef, busy all 0; internal divider registers 0.
- Opcodes: 0 ADD, 1 SUB, 2 MUL, 3 DIV, 4 AND, 5 OR, 6 NAND, 7 NOR, 8 XOR, 9 XNOR, A CMP_EQ, B CMP_GT, C SHR, D SHL, E ROR, F ROL.
- Flag and arithmetic rules match the ALU function set:
  - ADD/SUB: CF is bit DATA_WIDTH; OF is the signed rule; the result upper half is 0.
  - MUL: full 2W product; OF = upper half nonzero; CF=0.
  - Logic ops: zero-extended; CF=OF=0.
  - CMP: result bit0 = comparison; ZF=0.
  - EF = (a==b) for every op except CMP_EQ, where EF = the result.
- Shifts and rotates by n = b[SHAMT_WIDTH-1:0]:
  - n=0: result=a, CF=0, OF=0.
  - SHR: CF = a[n-1].
  - SHL: CF = a[W-n]; OF = MSB changed.
  - ROR/ROL: CF = the last bit rotated; OF=0.
  - ZF = lower half ==0.
- States are IDLE, DIV, HOLD.
- in_ready = (state==IDLE) && (!out_valid || out_ready).
- A transfer occurs when in_valid && in_ready; operands and opcode are captured on that edge.
- Non-DIV op in IDLE: result and flags are registered on the accept edge. out_valid=1 the next cycle (latency 1). The state stays IDLE, so back-to-back ops run at one per cycle when out_ready=1.
- DIV with b!=0: go to DIV, busy=1, counter loads DATA_WIDTH-1.
  - Each cycle performs one restoring step.
  - When counter==0, result/flags are registered and out_valid=1. The cycle that follows returns to IDLE.
  - Latency is DATA_WIDTH+1 cycles from accept to out_valid. in_ready=0 throughout.
  - DIV flags: ZF = quotient==0, CF=0, OF=0.
- DIV with b==0: no iteration. result is all ones, CF=1, latency 1.
- Output hold: while out_valid && !out_ready, result and flags are stable and in_ready=0.
  - If a DIV finishes while the output slot is still occupied, the FSM goes to HOLD and stays there until out_ready. It then loads the result and returns to IDLE.
- out_valid clears on out_ready unless a new result is loaded in the same cycle.
- Simultaneous accept and drain are allowed.
- Undefined opcode: impossible with OP_WIDTH=4. For wider OP_WIDTH, result=0, flags=0, latency 1.
- Reset mid-DIV aborts the operation and produces no output.

Optional Feature:
- Macro: ALU_SEQ_SIGNED_EN.
- Defined:
  - Adds input port op_signed (1 bit), captured with the operation.
  - When op_signed=1: CMP_GT is a signed compare; SHR becomes arithmetic (sign fill); MUL is a signed 2W product, with OF = upper half not equal to the sign extension of the lower half; DIV is signed, with the quotient truncated toward zero and the remainder taking the sign of A. DIV of the most-negative value by -1 gives quotient = most-negative and OF=1.
- Undefined: the port is absent and all ops are unsigned as above.

Decomposition:
- ALU_PACKAGE (extended): alu_op_e enum; alu_flags_t struct {cf, of, zf, ef}; alu_seq_state_e.
- DATA_WIDTH is taken from UART_PACKAGE.
- One sub-module: alu_seq_divider.
  - Iterative restoring divider with start/done.
  - Handles the divide-by-zero and signed fix-ups.

Test Plan (DATA_WIDTH=8):
- ADD a=0xFF, b=0x01, out_ready=1 → one cycle later result=0x0000, CF=1, ZF=1, OF=0. Then SUB a=0x80, b=0x01 on the next cycle → result=0x007F, OF=1.
- MUL a=0x10, b=0x10 → result=0x0100, OF=1, ZF=0, latency 1.
- DIV a=0x64, b=0x07 → in_ready low for 8 cycles; out_valid at accept+9; result=0x020E (rem 2, quot 14).
- DIV a=0x05, b=0x00 → result=0xFFFF, CF=1 at accept+1.
- SHL a=0x81, b=0x03 → result=0x0008, CF=0, OF=1. Then ROR a=0x01, b=0x01 → result=0x0080, CF=1.
- Backpressure: hold out_ready=0 after ADD 3+4 → result 0x0007 stays stable 5 cycles and in_ready=0. Then assert out_ready → accept resumes. Assert RST mid-DIV → out_valid=0, busy=0, state IDLE.
